dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port data memory. Port A is the
//  CPU datapath (load/store) and port B is a secondary master (DMA/debug loader).

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port ids, latency limit.
package dmem_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int LAT_MAX = 15;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_done;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_rdata, a_done, b_rdata, b_done,
        output mem_addr, mem_wdata, mem_write, mem_read, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_rdata, a_done, b_rdata, b_done,
        input  mem_addr, mem_wdata, mem_write, mem_read, busy
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is granted.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_ptr,
    output logic o_gnt_valid,
    output logic o_gnt_id
);
    always_comb begin
        o_gnt_valid = i_a_req | i_b_req;
        o_gnt_id    = PORT_A;
        if (i_a_req && i_b_req) begin
            o_gnt_id = (i_ptr == PORT_A) ? PORT_B : PORT_A;
        end else if (i_b_req) begin
            o_gnt_id = PORT_B;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: grants A or B, holds strobes LAT cycles, returns data + done.
// state    | meaning
// S_IDLE   | waiting for a request; grant latches owner and request fields
// S_ACCESS | memory strobes driven from latched fields for LAT cycles
// S_RESP   | one-cycle done pulse to the owner, strobes low
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int CNT_W  = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    dmem_arbiter_if.slave bus
);
    generate
        if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_check
            $error("dmem_arbiter: LAT must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic w_gnt_valid;
    logic w_gnt_id;

    rr_arb2 u_rr_arb2 (
        .i_a_req     (bus.a_req),
        .i_b_req     (bus.b_req),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_owner   <= PORT_A;
            r_ptr     <= PORT_B;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state <= S_ACCESS;
                        r_owner <= w_gnt_id;
                        r_ptr   <= w_gnt_id;
                        r_cnt   <= CNT_INIT;
                        if (w_gnt_id == PORT_B) begin
                            r_we    <= bus.b_we;
                            r_addr  <= bus.b_addr;
                            r_wdata <= bus.b_wdata;
                        end else begin
                            r_we    <= bus.a_we;
                            r_addr  <= bus.a_addr;
                            r_wdata <= bus.a_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        // Read data is combinational from memory on the last strobe cycle.
                        if (!r_we) begin
                            if (r_owner == PORT_B) r_b_rdata <= bus.mem_rdata;
                            else                   r_a_rdata <= bus.mem_rdata;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_write = (r_state == S_ACCESS) &&  r_we;
    assign bus.mem_read  = (r_state == S_ACCESS) && !r_we;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.a_done    = (r_state == S_RESP) && (r_owner == PORT_A);
    assign bus.b_done    = (r_state == S_RESP) && (r_owner == PORT_B);
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a LAT=1 instance (index 0) and a LAT=3 instance (index 1).
module tb_dmem_arbiter;
    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] rdata;
        int          cyc;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .CNT_W(4)) dut1 (
        .i_clk (clk), .i_rst (rst1), .bus (bus1));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3), .CNT_W(4)) dut3 (
        .i_clk (clk), .i_rst (rst3), .bus (bus3));

    logic        req_q  [2][2];
    logic        we_q   [2][2];
    logic [31:0] addr_q [2][2];
    logic [31:0] wdata_q[2][2];
    logic        done_w [2][2];
    logic [31:0] rdata_w[2][2];

    assign bus1.a_req = req_q[0][0];   assign bus1.b_req = req_q[0][1];
    assign bus1.a_we  = we_q[0][0];    assign bus1.b_we  = we_q[0][1];
    assign bus1.a_addr = addr_q[0][0]; assign bus1.b_addr = addr_q[0][1];
    assign bus1.a_wdata = wdata_q[0][0]; assign bus1.b_wdata = wdata_q[0][1];
    assign bus3.a_req = req_q[1][0];   assign bus3.b_req = req_q[1][1];
    assign bus3.a_we  = we_q[1][0];    assign bus3.b_we  = we_q[1][1];
    assign bus3.a_addr = addr_q[1][0]; assign bus3.b_addr = addr_q[1][1];
    assign bus3.a_wdata = wdata_q[1][0]; assign bus3.b_wdata = wdata_q[1][1];

    assign done_w[0][0] = bus1.a_done;   assign done_w[0][1] = bus1.b_done;
    assign done_w[1][0] = bus3.a_done;   assign done_w[1][1] = bus3.b_done;
    assign rdata_w[0][0] = bus1.a_rdata; assign rdata_w[0][1] = bus1.b_rdata;
    assign rdata_w[1][0] = bus3.a_rdata; assign rdata_w[1][1] = bus3.b_rdata;

    // Memory models: word index is addr[11:0]; writes commit after LAT consecutive strobe cycles.
    logic [31:0] mem0[4096];
    logic [31:0] mem1[4096];
    int          wc1 = 0;

    assign bus1.mem_rdata = mem0[bus1.mem_addr[11:0]];
    assign bus3.mem_rdata = mem1[bus3.mem_addr[11:0]];

    always @(posedge clk) begin
        if (bus1.mem_write === 1'b1) mem0[bus1.mem_addr[11:0]] <= bus1.mem_wdata;
    end

    always @(posedge clk) begin
        if (bus3.mem_write === 1'b1) begin
            if (wc1 == 2) begin
                mem1[bus3.mem_addr[11:0]] <= bus3.mem_wdata;
                wc1 <= 0;
            end else begin
                wc1 <= wc1 + 1;
            end
        end else begin
            wc1 <= 0;
        end
    end

    int nw[2];
    int nr[2];
    int nbusy[2];
    int ndone[2];
    initial begin
        for (int i = 0; i < 2; i++) begin
            nw[i] = 0; nr[i] = 0; nbusy[i] = 0; ndone[i] = 0;
        end
    end
    always @(negedge clk) begin
        if (bus1.mem_write === 1'b1) nw[0] = nw[0] + 1;
        if (bus1.mem_read  === 1'b1) nr[0] = nr[0] + 1;
        if (bus1.busy      === 1'b1) nbusy[0] = nbusy[0] + 1;
        if (bus1.a_done === 1'b1 || bus1.b_done === 1'b1) ndone[0] = ndone[0] + 1;
        if (bus3.mem_write === 1'b1) nw[1] = nw[1] + 1;
        if (bus3.mem_read  === 1'b1) nr[1] = nr[1] + 1;
        if (bus3.busy      === 1'b1) nbusy[1] = nbusy[1] + 1;
        if (bus3.a_done === 1'b1 || bus3.b_done === 1'b1) ndone[1] = ndone[1] + 1;
    end

    sb_t sbq0[$];
    sb_t sbq1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the next expected completion whenever either instance pulses done.
    always @(negedge clk) begin
        sb_t e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (done_w[d][p] === 1'b1) begin
                    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: dut%0d port %0d pulsed at cyc %0d, none expected", d, p, cyc);
                    end else begin
                        if (d == 0) e = sbq0.pop_front();
                        else        e = sbq1.pop_front();
                        check("done_port", 32'(p), 32'(e.port));
                        check("done_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) check("rdata", rdata_w[d][p], e.rdata);
                        check("done_exclusive", 32'(done_w[d][1-p]), 32'd0);
                    end
                end
            end
        end
    end

    task automatic push(input int d, input int p, input logic rd, input logic [31:0] rdata, input int ecyc);
        sb_t e;
        e.port  = p[0];
        e.rd    = rd;
        e.rdata = rdata;
        e.cyc   = ecyc;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic run(input int d, input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        int k;
        we_q[d][p]    = we;
        addr_q[d][p]  = addr;
        wdata_q[d][p] = wdata;
        req_q[d][p]   = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done_w[d][p] !== 1'b1 && k < 60);
        if (k >= 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: dut%0d port %0d never signalled done", d, p);
        end
        req_q[d][p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s0;
        int s1;
        int s2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req_q[d][p] = 1'b0; we_q[d][p] = 1'b0;
                addr_q[d][p] = '0;  wdata_q[d][p] = '0;
            end
        end
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem0[900] = 32'd1000; mem0[1000] = 32'd5; mem0[1003] = 32'd12;
        mem1[900] = 32'd1000; mem1[1000] = 32'd5; mem1[1003] = 32'd12;
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_mem_write", 32'(bus1.mem_write), 32'd0);
        check("rst_mem_read", 32'(bus1.mem_read), 32'd0);
        check("rst_done", 32'({bus1.a_done, bus1.b_done}), 32'd0);
        check("rst_mem_addr", bus1.mem_addr, 32'd0);
        check("rst_a_rdata", bus1.a_rdata, 32'd0);
        check("rst3_busy", 32'(bus3.busy), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        // Tie right after reset: A first, B three cycles after A's done.
        c = cyc;
        push(0, 0, 1'b1, 32'd5, c + 2);
        push(0, 1, 1'b1, 32'd12, c + 5);
        fork
            run(0, 0, 1'b0, 32'd1000, 32'd0);
            run(0, 1, 1'b0, 32'd1003, 32'd0);
        join
        @(posedge clk); #1;

        // Continuous contention: strict alternation A,B,A,B,A,B every three cycles.
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            push(0, 0, 1'b1, 32'd5,  c + 2 + 6*k);
            push(0, 1, 1'b1, 32'd12, c + 5 + 6*k);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    run(0, 0, 1'b0, 32'd1000, 32'd0);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    run(0, 1, 1'b0, 32'd1003, 32'd0);
                    @(posedge clk); #1;
                end
            end
        join

        // LAT=1 write then read back.
        s0 = nw[0];
        c = cyc;
        push(0, 0, 1'b0, 32'd0, c + 2);
        run(0, 0, 1'b1, 32'd900, 32'd77);
        @(posedge clk); #1;
        check("wr_strobe_cycles", 32'(nw[0] - s0), 32'd1);
        check("wr_mem_word", mem0[900], 32'd77);
        c = cyc;
        push(0, 0, 1'b1, 32'd77, c + 2);
        run(0, 0, 1'b0, 32'd900, 32'd0);
        @(posedge clk); #1;

        // Address passes through unmodified; memory aliases on [11:0].
        c = cyc;
        push(0, 0, 1'b1, 32'd5, c + 2);
        fork
            run(0, 0, 1'b0, 32'h0000_13E8, 32'd0);
            begin
                repeat (2) @(negedge clk);
                check("alias_mem_addr", bus1.mem_addr, 32'h0000_13E8);
                check("alias_mem_read", 32'(bus1.mem_read), 32'd1);
            end
        join
        @(posedge clk); #1;

        // LAT=3 read: three strobe cycles, busy four cycles.
        s0 = nr[1]; s1 = nbusy[1]; s2 = nw[1];
        c = cyc;
        push(1, 1, 1'b1, 32'd12, c + 4);
        run(1, 1, 1'b0, 32'd1003, 32'd0);
        @(posedge clk); #1;
        check("lat3_read_cycles", 32'(nr[1] - s0), 32'd3);
        check("lat3_busy_cycles", 32'(nbusy[1] - s1), 32'd4);
        check("lat3_write_cycles", 32'(nw[1] - s2), 32'd0);

        // Reset in the 2nd access cycle of a LAT=3 write aborts it.
        s0 = ndone[1];
        we_q[1][0] = 1'b1; addr_q[1][0] = 32'd1000; wdata_q[1][0] = 32'd99;
        req_q[1][0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort_pre_write", 32'(bus3.mem_write), 32'd1);
        rst3 = 1'b1;
        #1;
        check("abort_write_drop", 32'(bus3.mem_write), 32'd0);
        check("abort_busy_drop", 32'(bus3.busy), 32'd0);
        req_q[1][0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 32'(ndone[1] - s0), 32'd0);
        check("abort_mem_word", mem1[1000], 32'd5);

        // Post-reset tie on LAT=3 goes to A; B follows five cycles later.
        c = cyc;
        push(1, 0, 1'b1, 32'd12, c + 4);
        push(1, 1, 1'b1, 32'd5,  c + 9);
        fork
            run(1, 0, 1'b0, 32'd1003, 32'd0);
            run(1, 1, 1'b0, 32'd1000, 32'd0);
        join
        @(posedge clk); #1;
        check("a_rdata_held", bus3.a_rdata, 32'd12);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
